// File: rtl/digest_output_serializer_if.sv
// Output stream bus of the digest serializer: one WORD_W word per valid/ready transfer.
// The last word of a digest is flagged with out_last.
interface digest_output_serializer_if #(
   parameter int WORD_W = 32
);
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [WORD_W-1:0] out_data;

   modport master (
      output out_valid,
      output out_last,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_last,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/digest_output_serializer.sv
// Snapshots a NUM_WORDS*WORD_W digest on start and streams it out MSW (H0) first over
// a valid/ready bus; pulses done once the final word has been accepted.
module digest_output_serializer #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [WORD_W*NUM_WORDS-1:0] digest_in,
   output logic                        busy,
   output logic                        done,
   digest_output_serializer_if.master  out_bus
);
   localparam int DIGEST_W = WORD_W * NUM_WORDS;
   localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [DIGEST_W-1:0] r_shadow;
   logic [IDX_W-1:0]    r_idx;
   logic [WORD_W-1:0]   r_out_data;
   logic                r_out_valid;
   logic                r_busy;
   logic                r_done;

   logic [WORD_W-1:0]   w_words [NUM_WORDS];
   logic [IDX_W-1:0]    w_next_idx;
   logic                w_transfer;
   logic                w_last;

   // Word 0 is the most significant slice of the digest (big-endian order).
   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
      assign w_words[g] = r_shadow[DIGEST_W-1-WORD_W*g -: WORD_W];
   end

   assign w_next_idx = r_idx + 1'b1;
   assign w_transfer = r_out_valid & out_bus.out_ready;
   assign w_last     = (r_state == ST_SEND) && (r_idx == LAST_IDX);

   // out_data is loaded one word ahead from the shadow, so out_ready never reaches
   // out_data/out_valid combinationally.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: every register here uses <=, so all of them update from the same pre-edge
      // values and the branch order below cannot create read-after-write races.
      if (!reset_n) begin
         // NOTE: the shadow is plain flops rather than a memory, so it is cleared with
         // the rest of the state; a RAM-based snapshot would be left out of reset.
         r_state     <= ST_IDLE;
         r_shadow    <= '0;
         r_idx       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state     <= ST_SEND;
                  r_shadow    <= digest_in;
                  r_idx       <= '0;
                  r_out_data  <= digest_in[DIGEST_W-1 -: WORD_W];
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end

            ST_SEND: begin
               if (abort) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (w_transfer) begin
                  if (r_idx == LAST_IDX) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b0;
                     r_done      <= 1'b1;
                  end else begin
                     r_idx      <= w_next_idx;
                     r_out_data <= w_words[w_next_idx];
                  end
               end
            end

            ST_DONE: begin
               // start here is deliberately dropped; capture happens only from IDLE.
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_bus.out_valid = r_out_valid;
   assign out_bus.out_data  = r_out_data;
   assign out_bus.out_last  = w_last;
   assign busy              = r_busy;
   assign done              = r_done;
endmodule

// File: tb/tb_digest_output_serializer.sv
// Directed bench for digest_output_serializer: a vector table for full streams plus
// hand-written sequences for reset, back-pressure, abort and asynchronous reset.
module tb_digest_output_serializer;
   localparam logic [255:0] ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   typedef struct {
      logic         start;
      logic         abort;
      logic         ready;
      logic [255:0] din;
      logic         ev;
      logic         el;
      logic         eb;
      logic         ed;
      logic [31:0]  edata;
   } vec_t;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic         abort;
   logic [255:0] digest_in;
   logic         busy;
   logic         done;

   logic [31:0]  abc_w [8];
   vec_t         tbl [$];
   int           n_pass;
   int           n_total;

   digest_output_serializer_if #(.WORD_W(32)) bus ();

   digest_output_serializer #(
      .WORD_W    (32),
      .NUM_WORDS (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .digest_in (digest_in),
      .busy      (busy),
      .done      (done),
      .out_bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   function automatic void add(input logic s, input logic a, input logic r, input logic [255:0] d,
                               input logic ev, input logic el, input logic eb, input logic ed,
                               input logic [31:0] edata);
      vec_t v;
      v.start = s; v.abort = a; v.ready = r; v.din = d;
      v.ev = ev; v.el = el; v.eb = eb; v.ed = ed; v.edata = edata;
      tbl.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int  n;
      int  k;
      logic stalled;
      logic seen_done;
      logic [31:0] held;

      n_pass  = 0;
      n_total = 0;
      abc_w = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

      // Full "abc" stream, start during DONE ignored, then a second stream where start
      // carries abort (ignored in IDLE) and digest_in/start change mid-stream.
      add(1, 0, 1, ABC, 1, 0, 1, 0, abc_w[0]);
      for (int i = 1; i < 8; i++) add(0, 0, 1, ABC, 1, (i == 7), 1, 0, abc_w[i]);
      add(0, 0, 1, ABC, 0, 0, 1, 1, 32'h0);
      add(1, 0, 1, IV,  0, 0, 0, 0, 32'h0);
      add(0, 0, 1, IV,  0, 0, 0, 0, 32'h0);
      add(1, 1, 0, ABC, 1, 0, 1, 0, abc_w[0]);
      add(0, 0, 1, IV,  1, 0, 1, 0, abc_w[1]);
      add(1, 0, 1, IV,  1, 0, 1, 0, abc_w[2]);
      for (int i = 3; i < 8; i++) add((i == 5), 0, 1, IV, 1, (i == 7), 1, 0, abc_w[i]);
      add(0, 0, 1, IV, 0, 0, 1, 1, 32'h0);
      add(0, 0, 1, IV, 0, 0, 0, 0, 32'h0);

      // Reset and idle.
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; digest_in = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("idle%0d valid", i), {31'b0, bus.out_valid}, 32'h0);
         check($sformatf("idle%0d busy", i),  {31'b0, busy},          32'h0);
         check($sformatf("idle%0d done", i),  {31'b0, done},          32'h0);
         check($sformatf("idle%0d data", i),  bus.out_data,           32'h0);
      end

      // Table-driven vectors.
      foreach (tbl[i]) begin
         start = tbl[i].start; abort = tbl[i].abort;
         bus.out_ready = tbl[i].ready; digest_in = tbl[i].din;
         step();
         check($sformatf("row%0d valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].ev});
         check($sformatf("row%0d last", i),  {31'b0, bus.out_last},  {31'b0, tbl[i].el});
         check($sformatf("row%0d busy", i),  {31'b0, busy},          {31'b0, tbl[i].eb});
         check($sformatf("row%0d done", i),  {31'b0, done},          {31'b0, tbl[i].ed});
         if (tbl[i].ev) check($sformatf("row%0d data", i), bus.out_data, tbl[i].edata);
      end
      start = 1'b0; abort = 1'b0;

      // Back-pressure: ready pattern 1,0,0 repeating.
      start = 1'b1; digest_in = ABC; bus.out_ready = 1'b0;
      step();
      start = 1'b0;
      n = 0; k = 0; stalled = 1'b0; seen_done = 1'b0; held = '0;
      for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
         if (done) begin
            seen_done = 1'b1;
         end else begin
            bus.out_ready = (k % 3 == 0);
            k++;
            if (bus.out_valid) begin
               if (stalled) check($sformatf("stall hold n%0d", n), bus.out_data, held);
               if (bus.out_ready) begin
                  check($sformatf("stall xfer%0d data", n), bus.out_data, (n < 8) ? abc_w[n] : 32'hx);
                  check($sformatf("stall xfer%0d last", n), {31'b0, bus.out_last}, {31'b0, n == 7});
                  n++;
               end
               stalled = !bus.out_ready;
               held    = bus.out_data;
            end
            step();
         end
      end
      check("stall done seen", {31'b0, seen_done}, 32'h1);
      check("stall xfer count", n, 32'd8);
      step();

      // Abort after the third transfer, then restart from word 0.
      start = 1'b1; digest_in = ABC; bus.out_ready = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      check("abort pre data", bus.out_data, abc_w[3]);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort valid", {31'b0, bus.out_valid}, 32'h0);
      check("abort busy",  {31'b0, busy},          32'h0);
      check("abort done",  {31'b0, done},          32'h0);
      step();
      check("abort no done", {31'b0, done}, 32'h0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart data", bus.out_data, abc_w[0]);
      check("restart valid", {31'b0, bus.out_valid}, 32'h1);
      seen_done = 1'b0;
      for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
         step();
         if (done) seen_done = 1'b1;
      end
      check("restart done seen", {31'b0, seen_done}, 32'h1);
      step();

      // Asynchronous reset while word 5 is presented.
      start = 1'b1; digest_in = ABC; bus.out_ready = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      check("areset pre data", bus.out_data, abc_w[5]);
      #2 reset_n = 1'b0;
      #1;
      check("areset valid", {31'b0, bus.out_valid}, 32'h0);
      check("areset last",  {31'b0, bus.out_last},  32'h0);
      check("areset busy",  {31'b0, busy},          32'h0);
      check("areset done",  {31'b0, done},          32'h0);
      check("areset data",  bus.out_data,           32'h0);
      @(negedge clk);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post reset%0d valid", i), {31'b0, bus.out_valid}, 32'h0);
         check($sformatf("post reset%0d done", i),  {31'b0, done},          32'h0);
         check($sformatf("post reset%0d busy", i),  {31'b0, busy},          32'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
